// File: rtl/sync_fifo_lvl_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_lvl_pkg
//   Shared definitions for the level-tracking synchronous FIFO.
//   - fifo_op_e : encoding of the accepted operation in a cycle
//                 ({push_acc, pop_acc}), used for the level update.
//   - params_ok : legality check of DEPTH and the almost-full/empty
//                 thresholds, used by a simulation assertion in the top.
// ----------------------------------------------------------------------------
package sync_fifo_lvl_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // DEPTH >= 2, AFULL_TH in 1..DEPTH, AEMPTY_TH in 0..DEPTH-1
    function automatic bit params_ok(input int depth, input int afull_th,
                                     input int aempty_th);
        return (depth >= 2) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// ----------------------------------------------------------------------------
// sync_fifo_ptr
//   FIFO address pointer with wrap bit. Counts 0..DEPTH-1 and then returns to
//   0, toggling the wrap bit, so DEPTH need not be a power of two.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (ptr=0, wrap=0)
//   clr      in   synchronous clear (ptr=0, wrap=0), priority over inc
//   inc      in   advance the pointer by one
//   ptr      out  ADDR_W pointer value
//   wrap     out  wrap bit, toggles each time ptr passes DEPTH-1
// ----------------------------------------------------------------------------
module sync_fifo_ptr #(
    parameter int DEPTH  = 5,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap
);

    logic [ADDR_W-1:0] ptr_reg;
    logic              wrap_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg  <= '0;
            wrap_reg <= 1'b0;
        end else if (clr) begin
            ptr_reg  <= '0;
            wrap_reg <= 1'b0;
        end else if (inc) begin
            if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                ptr_reg  <= '0;
                wrap_reg <= ~wrap_reg;
            end else begin
                ptr_reg <= ptr_reg + 1'b1;
            end
        end
    end

    assign ptr  = ptr_reg;
    assign wrap = wrap_reg;

endmodule

// File: rtl/sync_fifo_lvl.sv
// ----------------------------------------------------------------------------
// sync_fifo_lvl
//   Single-clock first-word-fall-through FIFO with occupancy level,
//   programmable almost-full/almost-empty flags and sticky overflow/underflow.
//   Any DEPTH >= 2 is supported (no power-of-two pointer arithmetic).
// Ports:
//   clk, reset_n       clock (rising edge), async active-low reset
//   i_soft_reset       sync clear of pointers, level, memory and errors
//   i_put_en/_data     push request and data
//   i_get_en           pop request
//   o_get_data         head entry mem[rptr], valid when !o_empty
//   o_empty/o_full     level == 0 / level == DEPTH
//   o_afull/o_aempty   level >= AFULL_TH / level <= AEMPTY_TH
//   o_level            occupancy 0..DEPTH
//   i_clr_err          sync clear of sticky errors (a same-cycle set wins)
//   o_overflow         sticky: a push was dropped while full
//   o_underflow        sticky: a pop was ignored while empty
// ----------------------------------------------------------------------------
module sync_fifo_lvl
    import sync_fifo_lvl_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 5,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_soft_reset,
    input  logic              i_put_en,
    input  logic [DATA_W-1:0] i_put_data,
    input  logic              i_get_en,
    output logic [DATA_W-1:0] o_get_data,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [ADDR_W:0]   o_level,
    input  logic              i_clr_err,
    output logic              o_overflow,
    output logic              o_underflow
);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [ADDR_W:0]   level_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic              wwrap;
    logic              rwrap;
    logic              push_acc;
    logic              pop_acc;
    fifo_op_e          op;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it is paired with an accepted pop.
    assign pop_acc  = i_get_en && !o_empty;
    assign push_acc = i_put_en && (!o_full || pop_acc);
    assign op       = fifo_op_e'({push_acc, pop_acc});

    sync_fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (i_soft_reset),
        .inc     (push_acc),
        .ptr     (wptr),
        .wrap    (wwrap)
    );

    sync_fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (i_soft_reset),
        .inc     (pop_acc),
        .ptr     (rptr),
        .wrap    (rwrap)
    );

    // Storage is cleared on reset so that o_get_data reads 0 afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (i_soft_reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push_acc) begin
            mem_reg[wptr] <= i_put_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_reg <= '0;
        end else if (i_soft_reset) begin
            level_reg <= '0;
        end else begin
            case (op)
                OP_PUSH: level_reg <= level_reg + 1'b1;
                OP_POP:  level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky errors: a set in the same cycle as i_clr_err wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (i_soft_reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (i_put_en && !push_acc)
                overflow_reg <= 1'b1;
            else if (i_clr_err)
                overflow_reg <= 1'b0;

            if (i_get_en && o_empty)
                underflow_reg <= 1'b1;
            else if (i_clr_err)
                underflow_reg <= 1'b0;
        end
    end

    assign o_get_data  = mem_reg[rptr];
    assign o_level     = level_reg;
    assign o_empty     = (level_reg == '0);
    assign o_full      = (level_reg == (ADDR_W+1)'(DEPTH));
    assign o_afull     = (level_reg >= (ADDR_W+1)'(AFULL_TH));
    assign o_aempty    = (level_reg <= (ADDR_W+1)'(AEMPTY_TH));
    assign o_overflow  = overflow_reg;
    assign o_underflow = underflow_reg;

    // Cross-check: pointers equal with equal wrap bits means empty, with
    // differing wrap bits means full; both must agree with the level counter.
    logic ptr_empty;
    logic ptr_full;
    assign ptr_empty = (wptr == rptr) && (wwrap == rwrap);
    assign ptr_full  = (wptr == rptr) && (wwrap != rwrap);

    a_params_ok: assert property (@(posedge clk)
        params_ok(DEPTH, AFULL_TH, AEMPTY_TH));
    a_empty_agree: assert property (@(posedge clk) disable iff (!reset_n)
        ptr_empty == o_empty);
    a_full_agree: assert property (@(posedge clk) disable iff (!reset_n)
        ptr_full == o_full);

endmodule
